formula_sweep_checker: RTL and testbench



---
 rtl/bnsynth_chk_pkg.sv | 7 +
 rtl/formula_sweep_checker_cex_slot.sv | 24 ++
 rtl/formula_sweep_checker.sv | 84 ++++++++
 tb/tb_formula_sweep_checker.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bnsynth_chk_pkg.sv
// bnsynth_chk_pkg: shared state encoding and counter width helper for the sweep checker
package bnsynth_chk_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   function automatic int cex_cnt_w(input int max_cex);
      return $clog2(max_cex + 1);
   endfunction
endpackage

// File: rtl/formula_sweep_checker_cex_slot.sv
// cex_slot: single-entry valid/ready holding register for one counterexample
module cex_slot #(
   parameter int W = 25
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_vec,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] vec
);
   // a load wins over a same-edge handshake so no bubble is inserted
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid <= 1'b0;
         vec <= '0;
      end else if (clr) valid <= 1'b0;
      else if (load) begin
         valid <= 1'b1;
         vec <= load_vec;
      end else if (ready) valid <= 1'b0;
endmodule

// File: rtl/formula_sweep_checker.sv
// formula_sweep_checker: exhaustively drives a combinational netlist and streams out falsifying assignments
module formula_sweep_checker
   import bnsynth_chk_pkg::*;
#(
   parameter int NUM_VARS = 25,
   parameter int MAX_CEX = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   output logic [NUM_VARS-1:0]             vec_o,
   input  logic                            res_i,
   output logic                            cex_valid,
   input  logic                            cex_ready,
   output logic [NUM_VARS-1:0]             cex_vec,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [NUM_VARS:0]               checked,
   output logic [cex_cnt_w(MAX_CEX)-1:0]   cex_count
);
   localparam int CW = cex_cnt_w(MAX_CEX);
   state_t state;
   logic aborted;
   logic stall, eval, start_ok;
   logic [CW-1:0] cnt_next;
   assign stall = cex_valid && !cex_ready;
   assign eval = (state == RUN) && !stall;
   assign start_ok = start && (state == IDLE || state == DONE);
   assign cnt_next = cex_count + CW'(!res_i);
   cex_slot #(.W(NUM_VARS)) u_slot (
      .clk(clk),
      .rst(rst),
      .clr(start_ok),
      .load(eval && !res_i),
      .load_vec(vec_o),
      .ready(cex_ready),
      .valid(cex_valid),
      .vec(cex_vec)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         vec_o <= '0;
         checked <= '0;
         cex_count <= '0;
         pass <= 1'b0;
         aborted <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE:
               if (start) begin
                  state <= RUN;
                  vec_o <= '0;
                  checked <= '0;
                  cex_count <= '0;
                  pass <= 1'b0;
                  aborted <= 1'b0;
                  busy <= 1'b1;
                  done <= 1'b0;
               end
            RUN:
               if (!stall) begin
                  checked <= checked + 1'b1;
                  cex_count <= cnt_next;
                  if (&vec_o || cnt_next == CW'(MAX_CEX) || abort) begin
                     state <= DRAIN;
                     aborted <= abort;
                  end else vec_o <= vec_o + 1'b1;
               end
            DRAIN:
               if (!stall) begin
                  state <= DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (cex_count == '0) && !aborted;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_formula_sweep_checker.sv
// tb_formula_sweep_checker: scoreboard bench driving the checker with a 4-input netlist stub
module tb_formula_sweep_checker;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cex_ready = 1'b1;
   logic [15:0] fail_mask = '0;
   logic [3:0] vec, cex_vec;
   logic res, cex_valid, busy, done, pass;
   logic [4:0] checked, cex_count;
   logic start2 = 1'b0;
   logic [3:0] vec2, cex_vec2;
   logic cex_valid2, busy2, done2, pass2;
   logic [4:0] checked2;
   logic [1:0] cex_count2;
   logic [3:0] q[$], q2[$];
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;
   assign res = ~fail_mask[vec];

   formula_sweep_checker #(.NUM_VARS(4), .MAX_CEX(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_o(vec), .res_i(res),
      .cex_valid(cex_valid), .cex_ready(cex_ready), .cex_vec(cex_vec), .busy(busy),
      .done(done), .pass(pass), .checked(checked), .cex_count(cex_count)
   );

   formula_sweep_checker #(.NUM_VARS(4), .MAX_CEX(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .vec_o(vec2), .res_i(1'b0),
      .cex_valid(cex_valid2), .cex_ready(1'b1), .cex_vec(cex_vec2), .busy(busy2),
      .done(done2), .pass(pass2), .checked(checked2), .cex_count(cex_count2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_start(input logic [15:0] m);
      fail_mask = m;
      for (int v = 0; v < 16; v++) if (m[v]) q.push_back(4'(v));
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && !done; i++) tick();
      check("done_timeout", done, 1);
   endtask

   always @(negedge clk)
      if (!rst && cex_valid && cex_ready) begin
         if (q.size() == 0) check("cex_extra", q.size(), 1);
         else check("cex_vec", cex_vec, q.pop_front());
      end

   always @(negedge clk)
      if (!rst && cex_valid2) begin
         if (q2.size() == 0) check("cex2_extra", q2.size(), 1);
         else check("cex2_vec", cex_vec2, q2.pop_front());
      end

   initial begin
      #1;
      check("rst_vec", vec, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_checked", checked, 0);
      check("rst_cnt", cex_count, 0);
      check("rst_valid", cex_valid, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      // all-pass sweep with exact timing
      run_start(16'h0000);
      for (int i = 0; i < 16; i++) begin
         check("seq_vec", vec, i);
         tick();
      end
      check("done_early", done, 0);
      tick();
      check("done_at_17", done, 1);
      check("p1_pass", pass, 1);
      check("p1_checked", checked, 16);
      check("p1_cnt", cex_count, 0);
      // failures at 5 and 9, plus a start that must be ignored mid-run
      tick();
      run_start(16'h0220);
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      check("p2_pass", pass, 0);
      check("p2_checked", checked, 16);
      check("p2_cnt", cex_count, 2);
      // consumer stalls on the first counterexample
      tick();
      cex_ready = 1'b0;
      run_start(16'h0220);
      for (int i = 0; i < 20 && !cex_valid; i++) tick();
      check("stall_valid", cex_valid, 1);
      for (int i = 0; i < 10; i++) begin
         check("stall_vec", vec, 6);
         check("stall_checked", checked, 6);
         check("stall_cex", cex_vec, 5);
         tick();
      end
      cex_ready = 1'b1;
      wait_done();
      check("p3_cnt", cex_count, 2);
      check("p3_checked", checked, 16);
      // MAX_CEX=2 instance, stub always failing
      q2.push_back(4'd0);
      q2.push_back(4'd1);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 20 && !done2; i++) tick();
      check("m_done", done2, 1);
      check("m_checked", checked2, 2);
      check("m_cnt", cex_count2, 2);
      check("m_pass", pass2, 0);
      // one-cycle abort while vec is 7
      tick();
      run_start(16'h0000);
      for (int i = 0; i < 20 && vec != 4'd7; i++) tick();
      check("ab_vec", vec, 7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done();
      check("ab_checked", checked, 8);
      check("ab_pass", pass, 0);
      // asynchronous reset mid-run, then a clean rerun
      tick();
      run_start(16'h0000);
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b1;
      #1;
      check("ar_busy", busy, 0);
      check("ar_valid", cex_valid, 0);
      check("ar_vec", vec, 0);
      check("ar_checked", checked, 0);
      #1 rst = 1'b0;
      tick();
      run_start(16'h0000);
      check("rr_vec0", vec, 0);
      wait_done();
      check("rr_checked", checked, 16);
      check("rr_pass", pass, 1);
      tick();
      check("q_left", q.size(), 0);
      check("q2_left", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
